fabric_config_loader: RTL and testbench

Serial bitstream loader for the configurable fabric: receives a framed bitstream one bit per handshake, shifts the payload into shadow registers, verifies an 8-bit checksum, then commits atomically into the configuration words that drive every logic tile (33-bit LUT+FF-select word) and every 4x4 switch box (16-bit crossbar word). It is the writer for the fabric's configuration memories and sits between the external configuration port and the tile/switch-box array.

---
 rtl/fabric_config_loader_if.sv | 9 +
 rtl/fabric_config_loader.sv | 127 ++++++++++++
 tb/tb_fabric_config_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_config_loader_if.sv
// Serial configuration port: one bitstream bit per valid/ready handshake.
interface fabric_config_loader_if;
    logic cfg_in;
    logic cfg_valid;
    logic cfg_ready;

    modport master (output cfg_in, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_in, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fabric_config_loader.sv
// Framed serial bitstream loader: hunts for 8'hA5, shifts payload into a shadow,
// checks an 8-bit interleaved XOR checksum and commits tile/switch-box words atomically.
module fabric_config_loader #(
    parameter int TILES  = 38,
    parameter int BOXES  = 5,
    parameter int TILE_W = 33,
    parameter int BOX_W  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    fabric_config_loader_if.slave     cfg,
    output logic [TILES*TILE_W-1:0]   tile_cfg,
    output logic [BOXES*BOX_W-1:0]    box_cfg,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    localparam int TILE_BITS = TILES * TILE_W;
    localparam int BOX_BITS  = BOXES * BOX_W;
    localparam int P         = TILE_BITS + BOX_BITS;
    localparam int CNT_W     = $clog2(P + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {HUNT, LOAD, TRAILER, CHECK} state_t;

    state_t             state_reg;
    logic [7:0]         sync_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         trl_cnt_reg;
    logic [7:0]         chk_reg;
    logic [7:0]         trl_reg;
    logic [P-1:0]       shadow_reg;
    logic [P-1:0]       commit_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;

    logic               accept;
    logic [7:0]         sync_next;

    assign accept        = cfg.cfg_valid && ready_reg;
    assign sync_next     = {sync_reg[6:0], cfg.cfg_in};
    assign cfg.cfg_ready = ready_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign error         = error_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= HUNT;
            sync_reg    <= '0;
            cnt_reg     <= '0;
            trl_cnt_reg <= '0;
            chk_reg     <= '0;
            trl_reg     <= '0;
            shadow_reg  <= '0;
            commit_reg  <= '0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            case (state_reg)
                HUNT: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        sync_reg <= sync_next;
                        if (sync_next == SYNC) begin
                            cnt_reg   <= '0;
                            chk_reg   <= '0;
                            done_reg  <= 1'b0;
                            error_reg <= 1'b0;
                            busy_reg  <= 1'b1;
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shadow_reg[cnt_reg]     <= cfg.cfg_in;
                        // Payload bit k folds into checksum lane k mod 8.
                        chk_reg[cnt_reg[2:0]]   <= chk_reg[cnt_reg[2:0]] ^ cfg.cfg_in;
                        if (cnt_reg == CNT_W'(P - 1)) begin
                            cnt_reg     <= '0;
                            trl_cnt_reg <= '0;
                            state_reg   <= TRAILER;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                TRAILER: begin
                    if (accept) begin
                        trl_reg[trl_cnt_reg] <= cfg.cfg_in;
                        trl_cnt_reg          <= trl_cnt_reg + 3'd1;
                        if (trl_cnt_reg == 3'd7) begin
                            ready_reg <= 1'b0;
                            state_reg <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (trl_reg == chk_reg) begin
                        commit_reg <= shadow_reg;
                        done_reg   <= 1'b1;
                    end else begin
                        error_reg  <= 1'b1;
                    end
                    sync_reg  <= '0;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= HUNT;
                end
                default: state_reg <= HUNT;
            endcase
        end
    end

    // Committed image is laid out tiles first, then switch boxes.
    for (genvar gi = 0; gi < TILES; gi++) begin : g_tile
        assign tile_cfg[gi*TILE_W +: TILE_W] = commit_reg[gi*TILE_W +: TILE_W];
    end
    for (genvar gi = 0; gi < BOXES; gi++) begin : g_box
        assign box_cfg[gi*BOX_W +: BOX_W] = commit_reg[TILE_BITS + gi*BOX_W +: BOX_W];
    end
endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader with TILES=2, BOXES=1 (82-bit payload).
module tb_fabric_config_loader;
    localparam int TILES  = 2;
    localparam int BOXES  = 1;
    localparam int TILE_W = 33;
    localparam int BOX_W  = 16;
    localparam int TBITS  = TILES * TILE_W;
    localparam int P      = TBITS + BOXES * BOX_W;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fabric_config_loader_if cfg_bus ();

    logic [TBITS-1:0]       tile_cfg;
    logic [BOXES*BOX_W-1:0] box_cfg;
    logic                   busy, done, error;

    fabric_config_loader #(.TILES(TILES), .BOXES(BOXES), .TILE_W(TILE_W), .BOX_W(BOX_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg      (cfg_bus),
        .tile_cfg (tile_cfg),
        .box_cfg  (box_cfg),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    int checks   = 0;
    int failures = 0;
    int ready_low = 0;

    localparam logic [TBITS-1:0] ALT_TILE = 66'h2_AAAA_AAAA_AAAA_AAAA;
    localparam logic [15:0]      ALT_BOX  = 16'hAAAA;

    logic [P-1:0] pay_alt;

    function automatic logic [7:0] calc_chk(input logic [P-1:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < P; k++) c[k % 8] = c[k % 8] ^ p[k];
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_bit(input logic b, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 1)) begin
                cfg_bus.cfg_valid = 1'b0;
                cfg_bus.cfg_in    = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
        end
        guard = 0;
        while (cfg_bus.cfg_ready !== 1'b1 && guard < 16) begin
            ready_low++;
            cfg_bus.cfg_valid = 1'b0;
            @(negedge clock);
            guard++;
        end
        if (guard >= 16) begin
            checks++; failures++;
            $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_bus.cfg_ready);
        end
        cfg_bus.cfg_in    = b;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clock);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic send_sync(input bit gaps);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(s[i], gaps);
    endtask

    task automatic send_frame(input logic [P-1:0] p, input logic [7:0] t, input bit gaps);
        send_sync(gaps);
        for (int k = 0; k < P; k++) send_bit(p[k], gaps);
        for (int i = 0; i < 8; i++) send_bit(t[i], gaps);
    endtask

    task automatic test_reset();
        cfg_bus.cfg_in = 1'b0; cfg_bus.cfg_valid = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error, busy, cfg_bus.cfg_ready} !== '0) begin
            failures++;
            $display("FAIL reset_state: got tile=%h box=%h d=%b e=%b b=%b r=%b required all 0",
                     tile_cfg, box_cfg, done, error, busy, cfg_bus.cfg_ready);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (cfg_bus.cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", cfg_bus.cfg_ready);
        end
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        longint t0;
        t0 = $time;
        send_frame(pay_alt, calc_chk(pay_alt), 1'b0);
        checks++;
        if ({busy, done, cfg_bus.cfg_ready} !== 3'b100) begin
            failures++;
            $display("FAIL good_check_cycle: busy/done/ready=%b required 100",
                     {busy, done, cfg_bus.cfg_ready});
        end
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error, busy} !== {ALT_TILE, ALT_BOX, 3'b100}) begin
            failures++;
            $display("FAIL good_commit: tile=%h box=%h d=%b e=%b b=%b required tile=%h box=%h d=1 e=0 b=0",
                     tile_cfg, box_cfg, done, error, busy, ALT_TILE, ALT_BOX);
        end
        checks++;
        if (($time - t0) / 10 != 99) begin
            failures++;
            $display("FAIL good_frame_time: got %0d cycles required 99", ($time - t0) / 10);
        end
        $display("test_good_frame done");
    endtask

    task automatic test_bad_trailer();
        logic [P-1:0] p;
        p = ~pay_alt;
        send_frame(p, calc_chk(p) ^ 8'h08, 1'b0);
        checks++;
        if ({done, error} !== 2'b00) begin
            failures++;
            $display("FAIL bad_flags_cleared: done/error=%b required 00", {done, error});
        end
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error} !== {ALT_TILE, ALT_BOX, 2'b01}) begin
            failures++;
            $display("FAIL bad_trailer: tile=%h box=%h d=%b e=%b required tile=%h box=%h d=0 e=1",
                     tile_cfg, box_cfg, done, error, ALT_TILE, ALT_BOX);
        end
        $display("test_bad_trailer done");
    endtask

    task automatic test_noise();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        checks++;
        if ({busy, error} !== 2'b01) begin
            failures++;
            $display("FAIL noise_no_sync: busy/error=%b required 01", {busy, error});
        end
        send_frame(pay_alt, calc_chk(pay_alt), 1'b0);
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error} !== {ALT_TILE, ALT_BOX, 2'b10}) begin
            failures++;
            $display("FAIL noise_commit: tile=%h box=%h d=%b e=%b required tile=%h box=%h d=1 e=0",
                     tile_cfg, box_cfg, done, error, ALT_TILE, ALT_BOX);
        end
        $display("test_noise done");
    endtask

    task automatic test_gaps();
        ready_low = 0;
        send_frame(pay_alt, calc_chk(pay_alt), 1'b1);
        checks++;
        if (ready_low != 0 || cfg_bus.cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL gaps_ready_frame: low_during_frame=%0d ready_in_check=%b required 0 and 0",
                     ready_low, cfg_bus.cfg_ready);
        end
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error, cfg_bus.cfg_ready} !== {ALT_TILE, ALT_BOX, 3'b101}) begin
            failures++;
            $display("FAIL gaps_commit: tile=%h box=%h d=%b e=%b r=%b required tile=%h box=%h d=1 e=0 r=1",
                     tile_cfg, box_cfg, done, error, cfg_bus.cfg_ready, ALT_TILE, ALT_BOX);
        end
        $display("test_gaps done");
    endtask

    task automatic test_embedded_sync();
        logic [P-1:0] p;
        logic [7:0]   s;
        s = 8'hA5;
        p = '0;
        for (int i = 0; i < 8; i++) p[10 + i] = s[7 - i];
        p[0] = 1'b1; p[65] = 1'b1; p[81] = 1'b1;
        send_frame(p, calc_chk(p), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL embed_busy: got %b required 1", busy);
        end
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error} !== {66'h2_0000_0000_0002_9401, 16'h8000, 2'b10}) begin
            failures++;
            $display("FAIL embed_commit: tile=%h box=%h d=%b e=%b required tile=200000000000029401 box=8000 d=1 e=0",
                     tile_cfg, box_cfg, done, error);
        end
        $display("test_embedded_sync done");
    endtask

    task automatic test_reset_mid_frame();
        send_sync(1'b0);
        for (int k = 0; k < 40; k++) send_bit(pay_alt[k], 1'b0);
        checks++;
        if ({busy, done} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_pre: busy/done=%b required 10", {busy, done});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tile_cfg, box_cfg, done, error, busy, cfg_bus.cfg_ready} !== '0) begin
            failures++;
            $display("FAIL midreset_clear: tile=%h box=%h d=%b e=%b b=%b r=%b required all 0",
                     tile_cfg, box_cfg, done, error, busy, cfg_bus.cfg_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_frame(pay_alt, calc_chk(pay_alt), 1'b0);
        @(negedge clock);
        checks++;
        if ({tile_cfg, box_cfg, done, error} !== {ALT_TILE, ALT_BOX, 2'b10}) begin
            failures++;
            $display("FAIL midreset_recommit: tile=%h box=%h d=%b e=%b required tile=%h box=%h d=1 e=0",
                     tile_cfg, box_cfg, done, error, ALT_TILE, ALT_BOX);
        end
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        for (int k = 0; k < P; k++) pay_alt[k] = k[0];
        test_reset();
        test_good_frame();
        test_bad_trailer();
        test_noise();
        test_gaps();
        test_embedded_sync();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
